timepulse_phase_sequencer: RTL and testbench
============================================

# timepulse_phase_sequencer

Free-running timepulse and phase sequencer that drives the service-gate control strobes. Each memory cycle (MCT) is divided into TP_COUNT timepulses T01..Tn, and each timepulse into 8 clock phases. The block emits the non-overlapping active-low read, write, clear and transfer strobes (RT_n, WT_n, CT_n, TT_n) and the one-hot timepulse lines. It also implements monitor stop and single-MCT stepping, plus a synchronous GOJAM restart.

## Interface

Parameters:
- TP_COUNT, 12, timepulses per MCT; legal range 2..12.

Ports:
- SIM_CLK  input  1  clock. All state changes occur on the rising edge.
- SIM_RST  input  1  reset; asynchronous, active-high.
- p4VSW  input  1  supply rail; no logic function.
- GND  input  1  ground rail; no logic function.
- GOJAM  input  1  synchronous restart request, level-sampled.
- MSTP  input  1  monitor stop request, level.
- MSTRT  input  1  monitor step. Acts on its rising edge, detected internally against the previous-cycle sample.
- T_n  output  12  one-hot active-low timepulse. Bit i low means T(i+1); bits ≥ TP_COUNT are always 1.
- RT_n, WT_n, CT_n, TT_n  output  1 each  active-low phase strobes.
- PHASE  output  3  current phase index 0..7.
- MCT_END  output  1  high for the single cycle of the last timepulse, phase 7.
- STOPPED  output  1  high while in HALT.

## Operation

- State: run state {RUN, HALT}, timepulse counter tp (1..TP_COUNT), phase counter ph (0..7), step_pending flag, MSTRT history bit.
- All outputs are registered and are a direct decode of the state registers. There is no combinational path from inputs to outputs.
- Phase decode in RUN (strobes are mutually exclusive):
  - RT_n low at ph 1–2.
  - WT_n low at ph 3–4.
  - CT_n low at ph 5.
  - TT_n low at ph 6.
  - No strobe at ph 0 or ph 7.
- In RUN:
  - ph increments every cycle.
  - When ph=7, ph wraps to 0 and tp increments.
  - At tp=TP_COUNT, ph=7, tp wraps to 1.
- Halt check, made only at tp=TP_COUNT, ph=7:
  - If MSTP=1 and step_pending=0: go to HALT with tp=1, ph=0.
  - If MSTP=1 and step_pending=1: clear step_pending and stay in RUN.
  - Otherwise: wrap normally.
- In HALT:
  - tp=1, ph=0 held.
  - T_n = all ones; all strobes high; STOPPED=1; MCT_END=0.
  - If MSTP=0: next cycle is RUN at T01 ph 0.
  - Else if an MSTRT rising edge is seen this cycle, or step_pending=1: next cycle is RUN at T01 ph 0 with step_pending cleared. This runs exactly one MCT, after which the halt check halts again.
- An MSTRT rising edge seen in RUN sets step_pending, which is consumed at the next halt check. Multiple edges before consumption count as one.
- GOJAM=1 takes priority over everything except reset. The next state is RUN, tp=1, ph=0, step_pending=0. Holding GOJAM keeps the block pinned at T01 ph 0, where no strobe is active.
- tp is never allowed to exceed TP_COUNT. Any illegal counter value recovers to tp=1, ph=0 on the next edge.

## Timing

- Reset values, applied asynchronously while SIM_RST=1:
  - State RUN, tp=1, ph=0, step_pending=0, MSTRT history=0.
  - T_n=12'hFFE (T01 active).
  - RT_n=WT_n=CT_n=TT_n=1; PHASE=0; MCT_END=0; STOPPED=0.
- The first rising edge after SIM_RST deasserts advances to ph 1.
- MCT length is TP_COUNT×8 cycles; the default is 96.
- From the halt check, STOPPED rises on the next edge. From RUN, MCT_END and STOPPED are never high in the same cycle.
- Step latency: an MSTRT edge sampled at edge k in HALT puts the block in RUN, T01 ph 0, after edge k+1.
- MSTP deasserted in HALT: RUN resumes one cycle later.
- MSTP changes mid-MCT have no effect until the halt check.

## Test plan

- Reset release with MSTP=0, default TP_COUNT:
  - T01 RT_n is low at cycles 1–2, WT_n at 3–4, CT_n at 5, TT_n at 6.
  - MCT_END is high at cycle 95; T_n returns to 12'hFFE at cycle 96.
  - No two strobes are ever low together.
- MSTP=1 held from reset: one full MCT runs, then STOPPED=1 from cycle 96 with all strobes high. It remains stopped for 50 cycles.
- In HALT, pulse MSTRT for 3 cycles: exactly 96 RUN cycles follow, with exactly one MCT_END, then HALT again. A held MSTRT level does not retrigger.
- MSTRT edge at T05 with MSTP=1: the MCT-end halt is skipped once, and the block halts at the end of the following MCT (cycle 192).
- GOJAM asserted at T07 ph 4 for 2 cycles: while it is held the block stays at T01 ph 0; afterwards counting restarts from T01, and step_pending is cleared.
- TP_COUNT=4:
  - T_n bits 4–11 are always 1.
  - The MCT is 32 cycles.
  - SIM_RST asserted mid-WT_n immediately forces the reset values without waiting for a clock edge.

Source files
------------

// File: rtl/timepulse_phase_sequencer.sv
// ---------------------------------------------------------------------------
// timepulse_phase_sequencer
//
// Free-running timepulse / phase sequencer for the service-gate strobes.
// A memory cycle (MCT) is TP_COUNT timepulses, each split into 8 phases.
// The block supports monitor stop, single-MCT stepping and GOJAM restart.
//
// Ports:
//   SIM_CLK   clock, all state changes on the rising edge
//   SIM_RST   asynchronous active-high reset
//   p4VSW     supply rail, no logic function
//   GND       ground rail, no logic function
//   GOJAM     synchronous restart request (level)
//   MSTP      monitor stop request (level)
//   MSTRT     monitor step, acts on a rising edge
//   T_n       one-hot active-low timepulse lines (bit i low = T(i+1))
//   RT_n      active-low read strobe      (phases 1-2)
//   WT_n      active-low write strobe     (phases 3-4)
//   CT_n      active-low clear strobe     (phase 5)
//   TT_n      active-low transfer strobe  (phase 6)
//   PHASE     current phase index 0..7
//   MCT_END   high during the last timepulse, phase 7
//   STOPPED   high while halted
// ---------------------------------------------------------------------------
module timepulse_phase_sequencer #(
   parameter int TP_COUNT = 12
) (
   input  logic        SIM_CLK,
   input  logic        SIM_RST,
   input  logic        p4VSW,
   input  logic        GND,
   input  logic        GOJAM,
   input  logic        MSTP,
   input  logic        MSTRT,
   output logic [11:0] T_n,
   output logic        RT_n,
   output logic        WT_n,
   output logic        CT_n,
   output logic        TT_n,
   output logic [2:0]  PHASE,
   output logic        MCT_END,
   output logic        STOPPED
);

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } runState_t;

   localparam logic [3:0] TpLast = 4'(TP_COUNT);

   runState_t  state_q, state_d;
   logic [3:0] tp_q, tp_d;
   logic [2:0] ph_q, ph_d;
   logic       stepPending_q, stepPending_d;
   logic       mstrtSample_q, mstrtHist_q;

   logic       mstrtRise;
   logic       tpLegal;
   logic       haltCheck;

   logic [11:0] tNext;
   logic        rtNext, wtNext, ctNext, ttNext;
   logic        mctEndNext, stoppedNext;

   // The rails carry no logic; they are gathered here so they stay connected.
   logic unusedRails;
   assign unusedRails = p4VSW | GND;

   // Next-state logic. MSTRT is registered once and then compared against
   // the previous sample, so a step edge takes effect one cycle after it is
   // first sampled. GOJAM overrides everything, a halted sequencer sits at
   // T01 ph 0, and any counter value outside 1..TP_COUNT falls back to T01.
   always_comb begin
      mstrtRise     = mstrtSample_q & ~mstrtHist_q;
      tpLegal       = (tp_q != 4'd0) && (tp_q <= TpLast);
      haltCheck     = (tp_q == TpLast) && (ph_q == 3'd7);
      state_d       = state_q;
      tp_d          = tp_q;
      ph_d          = ph_q;
      stepPending_d = stepPending_q;

      if (GOJAM) begin
         state_d       = RUN;
         tp_d          = 4'd1;
         ph_d          = 3'd0;
         stepPending_d = 1'b0;
      end else if (state_q == HALT) begin
         tp_d = 4'd1;
         ph_d = 3'd0;
         if (!MSTP) begin
            state_d = RUN;
         end else if (mstrtRise || stepPending_q) begin
            state_d       = RUN;
            stepPending_d = 1'b0;
         end
      end else if (!tpLegal) begin
         tp_d = 4'd1;
         ph_d = 3'd0;
      end else if (haltCheck) begin
         tp_d = 4'd1;
         ph_d = 3'd0;
         if (MSTP && !stepPending_q) begin
            state_d       = HALT;
            stepPending_d = mstrtRise;
         end else if (MSTP && stepPending_q) begin
            stepPending_d = 1'b0;
         end else begin
            stepPending_d = stepPending_q | mstrtRise;
         end
      end else begin
         ph_d          = ph_q + 3'd1;
         stepPending_d = stepPending_q | mstrtRise;
         if (ph_q == 3'd7) begin
            tp_d = tp_q + 4'd1;
         end
      end
   end

   // Output decode of the next state, so the registered outputs always agree
   // with the state registers they sit beside. Halt blanks every line.
   always_comb begin
      tNext       = '1;
      rtNext      = 1'b1;
      wtNext      = 1'b1;
      ctNext      = 1'b1;
      ttNext      = 1'b1;
      mctEndNext  = 1'b0;
      stoppedNext = (state_d == HALT);
      if (state_d == RUN) begin
         for (int i = 0; i < 12; i++) begin
            tNext[i] = (tp_d != 4'(i + 1));
         end
         rtNext     = !((ph_d == 3'd1) || (ph_d == 3'd2));
         wtNext     = !((ph_d == 3'd3) || (ph_d == 3'd4));
         ctNext     = (ph_d != 3'd5);
         ttNext     = (ph_d != 3'd6);
         mctEndNext = (tp_d == TpLast) && (ph_d == 3'd7);
      end
   end

   // State and output registers, cleared to T01 ph 0 in RUN on reset.
   always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
      if (SIM_RST) begin
         state_q       <= RUN;
         tp_q          <= 4'd1;
         ph_q          <= 3'd0;
         stepPending_q <= 1'b0;
         mstrtSample_q <= 1'b0;
         mstrtHist_q   <= 1'b0;
         T_n           <= 12'hFFE;
         RT_n          <= 1'b1;
         WT_n          <= 1'b1;
         CT_n          <= 1'b1;
         TT_n          <= 1'b1;
         PHASE         <= 3'd0;
         MCT_END       <= 1'b0;
         STOPPED       <= 1'b0;
      end else begin
         state_q       <= state_d;
         tp_q          <= tp_d;
         ph_q          <= ph_d;
         stepPending_q <= stepPending_d;
         mstrtSample_q <= MSTRT;
         mstrtHist_q   <= mstrtSample_q;
         T_n           <= tNext;
         RT_n          <= rtNext;
         WT_n          <= wtNext;
         CT_n          <= ctNext;
         TT_n          <= ttNext;
         PHASE         <= ph_d;
         MCT_END       <= mctEndNext;
         STOPPED       <= stoppedNext;
      end
   end

endmodule

// File: tb/tb_timepulse_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_timepulse_phase_sequencer
//
// Directed bench for timepulse_phase_sequencer. One instance uses the
// default 12 timepulses, a second uses 4. Expected output vectors are
// derived from the timepulse/phase position of each cycle and queued as
// stimulus is driven, then popped and compared half a cycle after the edge.
// ---------------------------------------------------------------------------
module tb_timepulse_phase_sequencer;

   typedef struct packed {
      logic [11:0] tN;
      logic [3:0]  strb;
      logic [2:0]  phase;
      logic        mctEnd;
      logic        stopped;
   } outVec_t;

   typedef struct {
      string   tag;
      outVec_t vec;
   } sbEntry_t;

   logic        clock;
   logic        reset;
   logic        reset4;
   logic        p4VSW;
   logic        gnd;
   logic        gojam;
   logic        mstp;
   logic        mstrt;
   logic        gojam4;
   logic        mstp4;
   logic        mstrt4;

   logic [11:0] tN12, tN4;
   logic        rt12, wt12, ct12, tt12;
   logic        rt4, wt4, ct4, tt4;
   logic [2:0]  phase12, phase4;
   logic        mctEnd12, mctEnd4;
   logic        stopped12, stopped4;

   int          assertCount;
   int          failCount;
   sbEntry_t    sbQueue[$];

   timepulse_phase_sequencer dut (
      .SIM_CLK (clock),
      .SIM_RST (reset),
      .p4VSW   (p4VSW),
      .GND     (gnd),
      .GOJAM   (gojam),
      .MSTP    (mstp),
      .MSTRT   (mstrt),
      .T_n     (tN12),
      .RT_n    (rt12),
      .WT_n    (wt12),
      .CT_n    (ct12),
      .TT_n    (tt12),
      .PHASE   (phase12),
      .MCT_END (mctEnd12),
      .STOPPED (stopped12)
   );

   timepulse_phase_sequencer #(.TP_COUNT(4)) dut4 (
      .SIM_CLK (clock),
      .SIM_RST (reset4),
      .p4VSW   (p4VSW),
      .GND     (gnd),
      .GOJAM   (gojam4),
      .MSTP    (mstp4),
      .MSTRT   (mstrt4),
      .T_n     (tN4),
      .RT_n    (rt4),
      .WT_n    (wt4),
      .CT_n    (ct4),
      .TT_n    (tt4),
      .PHASE   (phase4),
      .MCT_END (mctEnd4),
      .STOPPED (stopped4)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Expected outputs while running at timepulse tp (1-based), phase ph.
   function automatic outVec_t expRun(input int tp, input int ph, input int tpCount);
      outVec_t v;
      v.tN = '1;
      for (int i = 0; i < 12; i++) begin
         if (i == tp - 1) v.tN[i] = 1'b0;
      end
      v.strb = 4'b1111;
      case (ph)
         1, 2:    v.strb[3] = 1'b0;
         3, 4:    v.strb[2] = 1'b0;
         5:       v.strb[1] = 1'b0;
         6:       v.strb[0] = 1'b0;
         default: ;
      endcase
      v.phase   = 3'(ph);
      v.mctEnd  = (tp == tpCount) && (ph == 7);
      v.stopped = 1'b0;
      return v;
   endfunction

   // Expected outputs while halted.
   function automatic outVec_t expHalt();
      outVec_t v;
      v.tN      = '1;
      v.strb    = 4'b1111;
      v.phase   = 3'd0;
      v.mctEnd  = 1'b0;
      v.stopped = 1'b1;
      return v;
   endfunction

   // Drive the inputs for the coming edge and queue the expected result.
   task automatic applyStimulus(input logic g, input logic m, input logic s,
                                input outVec_t e, input string tag);
      sbEntry_t entry;
      gojam     = g;
      mstp      = m;
      mstrt     = s;
      entry.tag = tag;
      entry.vec = e;
      sbQueue.push_back(entry);
   endtask

   // Pop the oldest expectation and compare it with the selected instance.
   task automatic checkOutput(input bit sel);
      sbEntry_t entry;
      outVec_t  obs;
      if (sel) obs = outVec_t'({tN4, rt4, wt4, ct4, tt4, phase4, mctEnd4, stopped4});
      else     obs = outVec_t'({tN12, rt12, wt12, ct12, tt12, phase12, mctEnd12, stopped12});
      assertCount++;
      if (sbQueue.size() == 0) begin
         failCount++;
         $error("[TB] FAIL scoreboard_empty observed=%h expected=<entry>", obs);
      end else begin
         entry = sbQueue.pop_front();
         assert (obs === entry.vec) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", entry.tag, obs, entry.vec);
         end
      end
   endtask

   // One clock cycle: drive, clock, then check on the falling edge.
   task automatic step(input logic g, input logic m, input logic s,
                       input outVec_t e, input string tag, input bit sel);
      applyStimulus(g, m, s, e, tag);
      @(posedge clock);
      @(negedge clock);
      checkOutput(sel);
   endtask

   // Hold reset across an edge, check the reset values, then release.
   task automatic doReset(input bit sel, input logic m);
      gojam = 1'b0;
      mstp  = m;
      mstrt = 1'b0;
      if (sel) reset4 = 1'b1;
      else     reset  = 1'b1;
      @(posedge clock);
      @(negedge clock);
      applyStimulus(1'b0, m, 1'b0, expRun(1, 0, sel ? 4 : 12), sel ? "reset4" : "reset");
      checkOutput(sel);
      if (sel) reset4 = 1'b0;
      else     reset  = 1'b0;
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      p4VSW       = 1'b1;
      gnd         = 1'b0;
      reset       = 1'b1;
      reset4      = 1'b1;
      gojam       = 1'b0;
      mstp        = 1'b0;
      mstrt       = 1'b0;
      gojam4      = 1'b0;
      mstp4       = 1'b0;
      mstrt4      = 1'b0;
      @(negedge clock);

      $display("[TB] free run, two MCT boundaries");
      doReset(1'b0, 1'b0);
      for (int c = 1; c <= 96; c++) begin
         step(1'b0, 1'b0, 1'b0, expRun((c / 8) % 12 + 1, c % 8, 12),
              $sformatf("run c%0d", c), 1'b0);
      end

      $display("[TB] monitor stop held from reset");
      doReset(1'b0, 1'b1);
      for (int c = 1; c <= 95; c++) begin
         step(1'b0, 1'b1, 1'b0, expRun(c / 8 + 1, c % 8, 12),
              $sformatf("stop run c%0d", c), 1'b0);
      end
      for (int c = 96; c < 146; c++) begin
         step(1'b0, 1'b1, 1'b0, expHalt(), $sformatf("stop halt c%0d", c), 1'b0);
      end

      $display("[TB] single step from halt");
      step(1'b0, 1'b1, 1'b1, expHalt(), "step sample", 1'b0);
      for (int j = 1; j <= 96; j++) begin
         step(1'b0, 1'b1, (j <= 2), expRun((j - 1) / 8 + 1, (j - 1) % 8, 12),
              $sformatf("step run j%0d", j), 1'b0);
      end
      for (int j = 97; j < 107; j++) begin
         step(1'b0, 1'b1, 1'b0, expHalt(), $sformatf("step halt j%0d", j), 1'b0);
      end

      $display("[TB] step request during run skips one halt");
      doReset(1'b0, 1'b1);
      for (int c = 1; c <= 191; c++) begin
         step(1'b0, 1'b1, (c == 33 || c == 34), expRun((c / 8) % 12 + 1, c % 8, 12),
              $sformatf("skip run c%0d", c), 1'b0);
      end
      for (int c = 192; c < 196; c++) begin
         step(1'b0, 1'b1, 1'b0, expHalt(), $sformatf("skip halt c%0d", c), 1'b0);
      end

      $display("[TB] GOJAM restart clears pending step");
      doReset(1'b0, 1'b0);
      for (int c = 1; c <= 52; c++) begin
         step(1'b0, 1'b0, (c == 10 || c == 11), expRun(c / 8 + 1, c % 8, 12),
              $sformatf("jam pre c%0d", c), 1'b0);
      end
      for (int k = 0; k < 2; k++) begin
         step(1'b1, 1'b1, 1'b0, expRun(1, 0, 12), $sformatf("jam hold %0d", k), 1'b0);
      end
      for (int k = 1; k <= 95; k++) begin
         step(1'b0, 1'b1, 1'b0, expRun(k / 8 + 1, k % 8, 12),
              $sformatf("jam post k%0d", k), 1'b0);
      end
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b1, 1'b0, expHalt(), $sformatf("jam halt %0d", k), 1'b0);
      end

      $display("[TB] four-timepulse instance");
      doReset(1'b1, 1'b0);
      for (int c = 1; c <= 67; c++) begin
         step(1'b0, 1'b0, 1'b0, expRun((c / 8) % 4 + 1, c % 8, 4),
              $sformatf("tp4 c%0d", c), 1'b1);
      end
      reset4 = 1'b1;
      #1;
      applyStimulus(1'b0, 1'b0, 1'b0, expRun(1, 0, 4), "tp4 async reset");
      checkOutput(1'b1);
      @(negedge clock);
      reset4 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
